axi_csr_bank: RTL and testbench

AXI_CSR_BANK -- requirements
Module: axi_csr_bank

---
 rtl/axi_csr_pkg.sv | 24 ++
 rtl/axi_csr_regfile.sv | 66 ++++++
 rtl/axi_csr_bank.sv | 218 +++++++++++++++++++++
 tb/tb_axi_csr_bank.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_csr_pkg.sv
// Shared encodings for the AXI CSR bank: burst types, response codes and FSM states.
package axi_csr_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Only FIXED and INCR are served; WRAP and the reserved code are errors.
    function automatic logic burst_bad(input logic [1:0] burst);
        return (burst == BURST_WRAP) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/axi_csr_regfile.sv
// Register storage with byte-strobe writes, read-only status passthrough and W1C semantics.
module axi_csr_regfile #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 32,
    parameter int unsigned          IDX_W    = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]  W1C_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [IDX_W-1:0]             widx,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    logic [DATA_W-1:0] store_q [NUM_REGS];
    logic [DATA_W-1:0] store_d [NUM_REGS];
    logic [DATA_W-1:0] strb_bits;
    logic [DATA_W-1:0] wr_bits;
    logic [DATA_W-1:0] set_bits;

    always_comb begin
        strb_bits = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            strb_bits[b*8 +: 8] = {8{wstrb[b]}};
        end
        wr_bits  = '0;
        set_bits = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            store_d[i] = store_q[i];
            wr_bits    = (we && (widx == IDX_W'(i))) ? strb_bits : '0;
            set_bits   = hw_set[i*DATA_W +: DATA_W] & {DATA_W{W1C_MASK[i]}};
            if (RO_MASK[i]) begin
                store_d[i] = '0;
            end else if (W1C_MASK[i]) begin
                // Set is OR-ed in after the clear so a same-cycle set wins.
                store_d[i] = (store_q[i] & ~(wdata & wr_bits)) | set_bits;
            end else begin
                store_d[i] = (store_q[i] & ~wr_bits) | (wdata & wr_bits);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst_n) begin
                store_q[i] <= '0;
            end else begin
                store_q[i] <= store_d[i];
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = store_q[i]
                                      | (hw_status[i*DATA_W +: DATA_W] & {DATA_W{RO_MASK[i]}});
        end
    end

endmodule

// File: rtl/axi_csr_bank.sv
// AXI4 slave CSR bank: independent single-outstanding write and read FSMs over a register file.
module axi_csr_bank
    import axi_csr_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 32,
    parameter int unsigned          ADDR_W   = 7,
    parameter int unsigned          ID_W     = 5,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]  W1C_MASK = '0
) (
    input  logic                         s_aclk,
    input  logic                         s_aresetn,
    input  logic [ID_W-1:0]              s_axi_awid,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic [7:0]                   s_axi_awlen,
    input  logic [2:0]                   s_axi_awsize,
    input  logic [1:0]                   s_axi_awburst,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wlast,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [ID_W-1:0]              s_axi_bid,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ID_W-1:0]              s_axi_arid,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_W-1:0]              s_axi_rid,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set_i
);

    localparam int unsigned SHIFT   = $clog2(DATA_W / 8);
    // Headroom so an INCR burst of up to 256 beats never wraps back into range.
    localparam int unsigned IDX_W   = ADDR_W + 9;
    localparam logic [2:0]  SIZE_OK = 3'(SHIFT);

    logic              live_q;
    logic [1:0]        w_state_q;
    logic [ID_W-1:0]   wid_q;
    logic [IDX_W-1:0]  widx_q;
    logic [7:0]        wlen_q, wcnt_q;
    logic [1:0]        wburst_q, bresp_q;
    logic              werr_q;
    logic              wbeat_err, reg_we, wlast_beat;

    logic [0:0]        r_state_q;
    logic [ID_W-1:0]   rid_q;
    logic [IDX_W-1:0]  ridx_q, rd_idx;
    logic [7:0]        rlen_q, rcnt_q;
    logic [1:0]        rburst_q, rresp_q;
    logic              rerr_q, rlast_q, rd_err, rd_bad;
    logic [DATA_W-1:0] rdata_q, rd_word;

    assign s_axi_awready = live_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = live_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

    always_comb begin
        wbeat_err  = werr_q || (widx_q >= IDX_W'(NUM_REGS));
        reg_we     = (w_state_q == W_DATA) && s_axi_wvalid && !wbeat_err;
        wlast_beat = s_axi_wlast || (wcnt_q == wlen_q);
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= BURST_FIXED;
            werr_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            live_q <= 1'b1;
            case (w_state_q)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        wid_q     <= s_axi_awid;
                        widx_q    <= IDX_W'(s_axi_awaddr >> SHIFT);
                        wlen_q    <= s_axi_awlen;
                        wburst_q  <= s_axi_awburst;
                        wcnt_q    <= '0;
                        werr_q    <= burst_bad(s_axi_awburst) || (s_axi_awsize != SIZE_OK);
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        werr_q <= wbeat_err;
                        wcnt_q <= wcnt_q + 8'd1;
                        if (wburst_q == BURST_INCR) begin
                            widx_q <= widx_q + IDX_W'(1);
                        end
                        if (wlast_beat) begin
                            bresp_q   <= wbeat_err ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Index and data for the beat about to be loaded into the R registers.
    always_comb begin
        rd_idx = IDX_W'(s_axi_araddr >> SHIFT);
        rd_err = burst_bad(s_axi_arburst) || (s_axi_arsize != SIZE_OK);
        if (r_state_q == R_DATA) begin
            rd_idx = ridx_q + ((rburst_q == BURST_INCR) ? IDX_W'(1) : IDX_W'(0));
            rd_err = rerr_q;
        end
        rd_bad  = rd_err || (rd_idx >= IDX_W'(NUM_REGS));
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rd_err && (rd_idx == IDX_W'(i))) begin
                rd_word = reg_q_o[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= BURST_FIXED;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        rid_q     <= s_axi_arid;
                        ridx_q    <= rd_idx;
                        rlen_q    <= s_axi_arlen;
                        rburst_q  <= s_axi_arburst;
                        rcnt_q    <= '0;
                        rerr_q    <= rd_err;
                        rdata_q   <= rd_word;
                        rresp_q   <= rd_bad ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            ridx_q  <= rd_idx;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata_q <= rd_word;
                            rresp_q <= rd_bad ? RESP_SLVERR : RESP_OKAY;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axi_csr_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK),
        .W1C_MASK (W1C_MASK)
    ) u_regfile (
        .clk       (s_aclk),
        .rst_n     (s_aresetn),
        .we        (reg_we),
        .widx      (widx_q),
        .wdata     (s_axi_wdata),
        .wstrb     (s_axi_wstrb),
        .hw_status (hw_status_i),
        .hw_set    (hw_set_i),
        .reg_q     (reg_q_o)
    );

endmodule

// File: tb/tb_axi_csr_bank.sv
// Scoreboard bench for axi_csr_bank: 32 x 32-bit regs, reg 1 W1C, reg 3 read-only.
module tb_axi_csr_bank;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 8;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rstn;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [NR*DW-1:0] reg_q, hw_status, hw_set;

    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];

    logic [DW-1:0] mdl [NR];
    logic [DW-1:0] stat3;
    logic [DW-1:0] beat_data [8];
    logic [3:0]    beat_strb [8];
    logic [DW-1:0] beat_set  [8];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    axi_csr_bank #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .ID_W     (IW),
        .RO_MASK  (32'h0000_0008),
        .W1C_MASK (32'h0000_0002)
    ) dut (
        .s_aclk        (clk),
        .s_aresetn     (rstn),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_q_o       (reg_q),
        .hw_status_i   (hw_status),
        .hw_set_i      (hw_set)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check_eq($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*DW +: DW]),
                     64'((i == 3) ? stat3 : mdl[i]));
        end
    endtask

    task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d,
                          input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic set_beats(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int b = 0; b < 8; b++) begin
            beat_data[b] = base + DW'(b) * step;
            beat_strb[b] = 4'hF;
            beat_set[b]  = '0;
        end
        if (n > 8) $display("set_beats: too many beats requested");
    endtask

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                             input logic [1:0] exp_resp);
        b_exp_t e;
        int n;
        e.id = id; e.resp = exp_resp;
        b_q.push_back(e);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check_eq("aw_timeout", 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = beat_data[b]; wstrb = beat_strb[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n == 50) check_eq("w_timeout", 0, 1);
            hw_set[1*DW +: DW] = beat_set[b];
            @(negedge clk);
            hw_set = '0;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check_eq("b_timeout", 0, 1);
        else if (b_q.size() == 0) check_eq("b_unexpected", 1, 0);
        else begin
            e = b_q.pop_front();
            check_eq("bid", 64'(bid), 64'(e.id));
            check_eq("bresp", 64'(bresp), 64'(e.resp));
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat);
        r_exp_t e;
        int n;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check_eq("ar_timeout", 0, 1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        check_eq("r_latency", 64'(rvalid), 1);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n == 50) check_eq("r_timeout", 0, 1);
            if (b == stall_beat) begin
                rready = 1'b0;
                @(negedge clk);
                check_eq("r_hold_valid", 64'(rvalid), 1);
                rready = 1'b1;
            end
            if (r_q.size() == 0) check_eq("r_unexpected", 1, 0);
            else begin
                e = r_q.pop_front();
                check_eq("rid", 64'(rid), 64'(e.id));
                check_eq("rdata", 64'(rdata), 64'(e.data));
                check_eq("rresp", 64'(rresp), 64'(e.resp));
                check_eq("rlast", 64'(rlast), 64'(e.last));
            end
            @(negedge clk);
        end
        rready = 1'b0;
        check_eq("r_done_idle", 64'(rvalid), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0; hw_status = '0; hw_set = '0; stat3 = '0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        set_beats(1, 32'h0, 32'h0);

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 64'(awready), 0);
        check_eq("rst_arready", 64'(arready), 0);
        check_eq("rst_wready", 64'(wready), 0);
        check_eq("rst_valids", 64'({bvalid, rvalid, rlast}), 0);
        check_eq("rst_resps", 64'({bresp, rresp, bid, rid}), 0);
        check_eq("rst_rdata", 64'(rdata), 0);
        check_regs("rst");
        rstn = 1'b1;
        check_eq("rel_awready_same", 64'(awready), 0);
        @(negedge clk);
        check_eq("rel_awready", 64'(awready), 1);
        check_eq("rel_arready", 64'(arready), 1);

        // Single write/read
        beat_data[0] = 32'hDEADBEEF;
        axi_write(5'd3, 8'h00, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        mdl[0] = 32'hDEADBEEF;
        push_r(5'd7, 32'hDEADBEEF, 2'b00, 1'b1);
        axi_read(5'd7, 8'h00, 8'd0, 2'b01, -1);

        // INCR burst regs 4..7, read back with a stall on beat 1
        set_beats(4, 32'd1, 32'd1);
        axi_write(5'd9, 8'd16, 8'd3, 2'b01, 3'd2, 4, 2'b00);
        for (int i = 0; i < 4; i++) mdl[4+i] = DW'(i + 1);
        for (int i = 0; i < 4; i++) push_r(5'd1, DW'(i + 1), 2'b00, i == 3);
        axi_read(5'd1, 8'd16, 8'd3, 2'b01, 1);

        // Byte strobes on reg 2
        set_beats(1, 32'hFFFF_FFFF, 32'h0);
        axi_write(5'd2, 8'd8, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        beat_data[0] = 32'h0; beat_strb[0] = 4'b0010;
        axi_write(5'd2, 8'd8, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        mdl[2] = 32'hFFFF_00FF;
        push_r(5'd2, 32'hFFFF_00FF, 2'b00, 1'b1);
        axi_read(5'd2, 8'd8, 8'd0, 2'b01, -1);
        check_regs("strb");

        // Out-of-range index and partial out-of-range burst
        set_beats(2, 32'h31, 32'h1);
        axi_write(5'd4, 8'd128, 8'd0, 2'b01, 3'd2, 1, 2'b10);
        check_regs("oor");
        push_r(5'd4, 32'h0, 2'b10, 1'b1);
        axi_read(5'd4, 8'd128, 8'd0, 2'b01, -1);
        axi_write(5'd5, 8'd124, 8'd1, 2'b01, 3'd2, 2, 2'b10);
        mdl[31] = 32'h31;
        push_r(5'd5, 32'h31, 2'b00, 1'b0);
        push_r(5'd5, 32'h0, 2'b10, 1'b1);
        axi_read(5'd5, 8'd124, 8'd1, 2'b01, -1);

        // FIXED burst, WRAP burst, bad size, early wlast
        set_beats(2, 32'hA, 32'h1);
        axi_write(5'd6, 8'd32, 8'd1, 2'b00, 3'd2, 2, 2'b00);
        mdl[8] = 32'hB;
        axi_write(5'd6, 8'd36, 8'd1, 2'b10, 3'd2, 2, 2'b10);
        axi_write(5'd6, 8'd36, 8'd0, 2'b01, 3'd1, 1, 2'b10);
        set_beats(2, 32'h10, 32'h1);
        axi_write(5'd8, 8'd40, 8'd3, 2'b01, 3'd2, 2, 2'b00);
        mdl[10] = 32'h10; mdl[11] = 32'h11;
        check_regs("burst");
        push_r(5'd6, 32'hB, 2'b00, 1'b0);
        push_r(5'd6, 32'hB, 2'b00, 1'b1);
        axi_read(5'd6, 8'd32, 8'd1, 2'b00, -1);
        push_r(5'd6, 32'h0, 2'b10, 1'b1);
        axi_read(5'd6, 8'd0, 8'd0, 2'b10, -1);

        // Read-only reg 3
        stat3 = 32'h1234_5678;
        hw_status[3*DW +: DW] = stat3;
        set_beats(1, 32'hFFFF, 32'h0);
        axi_write(5'd10, 8'd12, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        push_r(5'd10, 32'h1234_5678, 2'b00, 1'b1);
        axi_read(5'd10, 8'd12, 8'd0, 2'b01, -1);

        // W1C reg 1
        hw_set[1*DW +: DW] = 32'h5;
        @(negedge clk);
        hw_set = '0;
        mdl[1] = 32'h5;
        check_regs("w1c_set");
        set_beats(1, 32'h1, 32'h0);
        axi_write(5'd11, 8'd4, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        push_r(5'd11, 32'h4, 2'b00, 1'b1);
        axi_read(5'd11, 8'd4, 8'd0, 2'b01, -1);
        beat_set[0] = 32'h1;
        axi_write(5'd12, 8'd4, 8'd0, 2'b01, 3'd2, 1, 2'b00);
        mdl[1] = 32'h5;
        push_r(5'd12, 32'h5, 2'b00, 1'b1);
        axi_read(5'd12, 8'd4, 8'd0, 2'b01, -1);

        // Reset during beat 2 of a 4-beat write
        set_beats(4, 32'h70, 32'h1);
        awid = 5'd13; awaddr = 8'd48; awlen = 8'd3; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = beat_data[b]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wdata = beat_data[2];
        rstn = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("midrst_bvalid", 64'(bvalid), 0);
        check_eq("midrst_wready", 64'(wready), 0);
        @(negedge clk);
        rstn = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        check_eq("midrst_awready", 64'(awready), 1);
        check_eq("midrst_bvalid_after", 64'(bvalid), 0);
        bready = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        check_regs("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
